// File: rtl/sa_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sa_ctrl
// Brief    : Job sequencer for a systolic matmul array: buffers B, replays it
//            in reverse row order, streams A and forwards C rows.
// Revision : 1.0
// ============================================================================
module sa_ctrl #(
    parameter int WIDTH   = 16,
    parameter int SIZE    = 2,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_keep_b,
    input  logic [CNT_W-1:0]      i_n_a,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    input  logic                  i_row_vld,
    output logic                  o_row_rdy,
    input  logic [SIZE*WIDTH-1:0] i_row_data,
    output logic                  o_sa_we,
    output logic                  o_sa_a_vld,
    output logic                  o_sa_c_vld,
    output logic [SIZE*WIDTH-1:0] o_sa_a_rows,
    input  logic                  i_sa_c_vld,
    input  logic [SIZE*WIDTH-1:0] i_sa_c_rows,
    output logic                  o_c_vld,
    output logic [SIZE*WIDTH-1:0] o_c_rows,
    output logic                  o_c_last
);
    localparam int ROW_W = SIZE * WIDTH;
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_B   = 3'd1,
        S_ISSUE_B  = 3'd2,
        S_STREAM_A = 3'd3,
        S_DRAIN    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               b_loaded_q, b_loaded_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   a_sent_q, a_sent_d;
    logic [CNT_W-1:0]   c_cnt_q, c_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               sa_we_q, sa_we_d;
    logic               sa_a_vld_q, sa_a_vld_d;
    logic               sa_c_vld_q, sa_c_vld_d;
    logic [ROW_W-1:0]   sa_rows_q, sa_rows_d;
    logic [ROW_W-1:0]   b_buf_q [SIZE];

    logic               w_c_win;
    logic               w_c_acc;
    logic [IDX_W-1:0]   w_issue_idx;

    // Result rows are only accepted while a job is collecting and short of n.
    assign w_c_win     = (state_q == S_STREAM_A) || (state_q == S_DRAIN);
    assign w_c_acc     = w_c_win && i_sa_c_vld && (c_cnt_q < n_q);
    assign w_issue_idx = IDX_LAST - idx_q;

    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_sa_we     = sa_we_q;
    assign o_sa_a_vld  = sa_a_vld_q;
    assign o_sa_c_vld  = sa_c_vld_q;
    assign o_sa_a_rows = sa_rows_q;
    assign o_c_vld     = w_c_acc;
    assign o_c_rows    = w_c_win ? i_sa_c_rows : '0;
    assign o_c_last    = w_c_acc && (c_cnt_q == n_q - CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        b_loaded_d = b_loaded_q;
        n_d        = n_q;
        a_sent_d   = a_sent_q;
        c_cnt_d    = c_cnt_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        sa_we_d    = 1'b0;
        sa_a_vld_d = 1'b0;
        sa_c_vld_d = 1'b0;
        sa_rows_d  = '0;
        o_row_rdy  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    n_d      = i_n_a;
                    a_sent_d = '0;
                    c_cnt_d  = '0;
                    idx_d    = '0;
                    tmo_d    = '0;
                    if (i_n_a == '0) begin
                        done_d = 1'b1;
                    end else if (i_keep_b && b_loaded_q) begin
                        state_d = S_STREAM_A;
                    end else begin
                        state_d    = S_LOAD_B;
                        b_loaded_d = 1'b0;
                    end
                end
            end
            S_LOAD_B: begin
                o_row_rdy = 1'b1;
                if (i_row_vld) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_ISSUE_B;
                    end
                end
            end
            S_ISSUE_B: begin
                // Reverse order: the array shifts weights in, so the last row goes first.
                sa_we_d    = 1'b1;
                sa_a_vld_d = 1'b1;
                sa_rows_d  = b_buf_q[w_issue_idx];
                idx_d      = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    idx_d      = '0;
                    state_d    = S_STREAM_A;
                    b_loaded_d = 1'b1;
                end
            end
            S_STREAM_A: begin
                o_row_rdy = (a_sent_q < n_q);
                if (o_row_rdy && i_row_vld) begin
                    sa_a_vld_d = 1'b1;
                    sa_c_vld_d = 1'b1;
                    sa_rows_d  = i_row_data;
                    a_sent_d   = a_sent_q + CNT_W'(1);
                    if (a_sent_q == n_q - CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_c_acc) begin
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_LAST) begin
                        state_d    = S_IDLE;
                        done_d     = 1'b1;
                        err_d      = 1'b1;
                        b_loaded_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_c_acc) begin
            c_cnt_d = c_cnt_q + CNT_W'(1);
            if (o_c_last) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            b_loaded_q <= 1'b0;
            n_q        <= '0;
            a_sent_q   <= '0;
            c_cnt_q    <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sa_we_q    <= 1'b0;
            sa_a_vld_q <= 1'b0;
            sa_c_vld_q <= 1'b0;
            sa_rows_q  <= '0;
        end else begin
            state_q    <= state_d;
            b_loaded_q <= b_loaded_d;
            n_q        <= n_d;
            a_sent_q   <= a_sent_d;
            c_cnt_q    <= c_cnt_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            done_q     <= done_d;
            err_q      <= err_d;
            sa_we_q    <= sa_we_d;
            sa_a_vld_q <= sa_a_vld_d;
            sa_c_vld_q <= sa_c_vld_d;
            sa_rows_q  <= sa_rows_d;
        end
    end

    // B buffer holds data only; it is never read before being rewritten after reset.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD_B && i_row_vld) begin
            b_buf_q[idx_q] <= i_row_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sa_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_ctrl
// Brief    : Directed self-checking bench for sa_ctrl with a small array model.
// Revision : 1.0
// ============================================================================
module tb_sa_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_keep_b = 1'b0;
    logic [7:0]  i_n_a = '0;
    logic        o_busy, o_done, o_err;
    logic        i_row_vld = 1'b0;
    logic        o_row_rdy;
    logic [31:0] i_row_data = '0;
    logic        o_sa_we, o_sa_a_vld, o_sa_c_vld;
    logic [31:0] o_sa_a_rows;
    logic        i_sa_c_vld;
    logic [31:0] i_sa_c_rows;
    logic        o_c_vld;
    logic [31:0] o_c_rows;
    logic        o_c_last;

    int n_tests = 0;
    int n_fail  = 0;

    sa_ctrl #(.WIDTH(16), .SIZE(2), .CNT_W(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_keep_b(i_keep_b), .i_n_a(i_n_a),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .i_row_vld(i_row_vld), .o_row_rdy(o_row_rdy), .i_row_data(i_row_data),
        .o_sa_we(o_sa_we), .o_sa_a_vld(o_sa_a_vld), .o_sa_c_vld(o_sa_c_vld),
        .o_sa_a_rows(o_sa_a_rows), .i_sa_c_vld(i_sa_c_vld), .i_sa_c_rows(i_sa_c_rows),
        .o_c_vld(o_c_vld), .o_c_rows(o_c_rows), .o_c_last(o_c_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input int e0, input int e1);
        return {e1[15:0], e0[15:0]};
    endfunction

    function automatic logic [31:0] mm(input logic [31:0] a, input logic [31:0] r0, input logic [31:0] r1);
        logic signed [15:0] c0, c1;
        c0 = $signed(a[15:0]) * $signed(r0[15:0])  + $signed(a[31:16]) * $signed(r1[15:0]);
        c1 = $signed(a[15:0]) * $signed(r0[31:16]) + $signed(a[31:16]) * $signed(r1[31:16]);
        return {c1, c0};
    endfunction

    // Array model: weights shift in on we, results appear three cycles after an A row.
    logic [31:0] w_row0 = '0, w_row1 = '0;
    logic [2:0]  p_vld = '0;
    logic [31:0] p_row0 = '0, p_row1 = '0, p_row2 = '0;
    logic        stub = 1'b0;
    always @(posedge clk) begin
        if (o_sa_we) begin
            w_row1 <= w_row0;
            w_row0 <= o_sa_a_rows;
        end
        p_vld  <= {p_vld[1:0], o_sa_a_vld & o_sa_c_vld & ~stub};
        p_row0 <= mm(o_sa_a_rows, w_row0, w_row1);
        p_row1 <= p_row0;
        p_row2 <= p_row1;
    end
    assign i_sa_c_vld  = p_vld[2];
    assign i_sa_c_rows = p_row2;

    // Event logs stamped with the cycle number of the sampling edge.
    int cyc = 0;
    logic [31:0] sa_rows_log[$];
    logic [2:0]  sa_flag_log[$];
    int          sa_t_log[$];
    logic [31:0] c_rows_log[$];
    logic        c_last_log[$];
    int          c_t_log[$];
    int          done_cnt = 0;
    int          done_t = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_sa_we | o_sa_a_vld | o_sa_c_vld) begin
            sa_rows_log.push_back(o_sa_a_rows);
            sa_flag_log.push_back({o_sa_we, o_sa_a_vld, o_sa_c_vld});
            sa_t_log.push_back(cyc);
        end
        if (o_c_vld) begin
            c_rows_log.push_back(o_c_rows);
            c_last_log.push_back(o_c_last);
            c_t_log.push_back(cyc);
        end
        if (o_done) begin
            done_cnt <= done_cnt + 1;
            done_t   <= cyc;
        end
    end

    function automatic logic [31:0] sa_row(input int i);
        return (i < sa_rows_log.size()) ? sa_rows_log[i] : 32'hxxxx_xxxx;
    endfunction
    function automatic logic [2:0] sa_flag(input int i);
        return (i < sa_flag_log.size()) ? sa_flag_log[i] : 3'bxxx;
    endfunction
    function automatic int sa_t(input int i);
        return (i < sa_t_log.size()) ? sa_t_log[i] : -1000;
    endfunction
    function automatic logic [32:0] c_ent(input int i);
        return (i < c_rows_log.size()) ? {c_last_log[i], c_rows_log[i]} : 33'hx_xxxx_xxxx;
    endfunction
    function automatic int c_t(input int i);
        return (i < c_t_log.size()) ? c_t_log[i] : -1000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] n, input logic kb);
        i_start  = 1'b1;
        i_n_a    = n;
        i_keep_b = kb;
        tick();
        i_start  = 1'b0;
        i_keep_b = 1'b0;
        i_n_a    = '0;
    endtask

    task automatic send(input logic [31:0] d, input string tag);
        bit ok;
        ok = 1'b0;
        i_row_vld  = 1'b1;
        i_row_data = d;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = o_row_rdy;
            tick();
        end
        i_row_vld = 1'b0;
        chk(tag, 64'(ok), 64'(1));
    endtask

    task automatic wait_done(input int max, output int k);
        k = 0;
        while (!o_done && k < max) begin
            tick();
            k++;
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {o_busy, o_done, o_err, o_row_rdy, o_sa_we, o_sa_a_vld, o_sa_c_vld,
                o_c_vld, o_c_last, o_sa_a_rows[15:0], o_c_rows[15:0]};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sb, cb, db, k;

        // Reset state
        tick(); tick();
        chk("reset_outputs", out_vec(), 64'(0));
        chk("reset_rows", 64'({o_sa_a_rows, o_c_rows}), 64'(0));
        rst = 1'b0;
        tick();

        // 1: full job, back-to-back rows
        sb = sa_rows_log.size(); cb = c_rows_log.size(); db = done_cnt;
        start_job(8'd2, 1'b0);
        chk("t1_busy_rdy", 64'({o_busy, o_row_rdy}), 64'(2'b11));
        send(pk(1, 2), "t1_b0_hs");
        send(pk(3, 4), "t1_b1_hs");
        send(pk(1, 2), "t1_a0_hs");
        send(pk(3, 4), "t1_a1_hs");
        chk("t1_rdy_drop", 64'({o_busy, o_row_rdy}), 64'(2'b10));
        wait_done(50, k);
        chk("t1_done_err", 64'({o_done, o_err}), 64'(2'b10));
        tick();
        chk("t1_issue0", 64'({sa_flag(sb), sa_row(sb)}), 64'({3'b110, pk(3, 4)}));
        chk("t1_issue1", 64'({sa_flag(sb + 1), sa_row(sb + 1)}), 64'({3'b110, pk(1, 2)}));
        chk("t1_issue_gap", 64'(sa_t(sb + 1) - sa_t(sb)), 64'(1));
        chk("t1_a0", 64'({sa_flag(sb + 2), sa_row(sb + 2)}), 64'({3'b011, pk(1, 2)}));
        chk("t1_a1", 64'({sa_flag(sb + 3), sa_row(sb + 3)}), 64'({3'b011, pk(3, 4)}));
        chk("t1_c0", 64'(c_ent(cb)), 64'({1'b0, pk(7, 10)}));
        chk("t1_c1", 64'(c_ent(cb + 1)), 64'({1'b1, pk(15, 22)}));
        chk("t1_c_gap", 64'(c_t(cb + 1) - c_t(cb)), 64'(1));
        chk("t1_done_after_last", 64'(done_t - c_t(cb + 1)), 64'(1));
        chk("t1_done_once", 64'(done_cnt - db), 64'(1));
        chk("t1_idle", 64'({o_busy, o_done}), 64'(0));

        // 2: same job with a one-cycle bubble between A rows
        sb = sa_rows_log.size(); cb = c_rows_log.size(); db = done_cnt;
        start_job(8'd2, 1'b0);
        send(pk(1, 2), "t2_b0_hs");
        send(pk(3, 4), "t2_b1_hs");
        send(pk(1, 2), "t2_a0_hs");
        tick();
        send(pk(3, 4), "t2_a1_hs");
        wait_done(50, k);
        chk("t2_done_err", 64'({o_done, o_err}), 64'(2'b10));
        tick(); tick(); tick();
        chk("t2_a_gap", 64'(sa_t(sb + 3) - sa_t(sb + 2)), 64'(2));
        chk("t2_a1", 64'({sa_flag(sb + 3), sa_row(sb + 3)}), 64'({3'b011, pk(3, 4)}));
        chk("t2_c_gap", 64'(c_t(cb + 1) - c_t(cb)), 64'(2));
        chk("t2_c0", 64'(c_ent(cb)), 64'({1'b0, pk(7, 10)}));
        chk("t2_c1", 64'(c_ent(cb + 1)), 64'({1'b1, pk(15, 22)}));
        chk("t2_done_once", 64'(done_cnt - db), 64'(1));

        // 3: keep_b reuses B, first handshake is already A
        sb = sa_rows_log.size(); cb = c_rows_log.size();
        start_job(8'd2, 1'b1);
        chk("t3_busy_rdy", 64'({o_busy, o_row_rdy}), 64'(2'b11));
        send(pk(1, 0), "t3_a0_hs");
        send(pk(0, 1), "t3_a1_hs");
        wait_done(50, k);
        chk("t3_done_err", 64'({o_done, o_err}), 64'(2'b10));
        tick();
        chk("t3_sa_count", 64'(sa_rows_log.size() - sb), 64'(2));
        chk("t3_a0", 64'({sa_flag(sb), sa_row(sb)}), 64'({3'b011, pk(1, 0)}));
        chk("t3_c0", 64'(c_ent(cb)), 64'({1'b0, pk(1, 2)}));
        chk("t3_c1", 64'(c_ent(cb + 1)), 64'({1'b1, pk(3, 4)}));

        // 4: reset during ISSUE_B, then keep_b must still reload B
        start_job(8'd2, 1'b0);
        send(pk(5, 6), "t4_b0_hs");
        send(pk(7, 8), "t4_b1_hs");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_rst_outputs", out_vec(), 64'(0));
        sb = sa_rows_log.size(); cb = c_rows_log.size();
        start_job(8'd2, 1'b1);
        send(pk(1, 2), "t4_b0r_hs");
        send(pk(3, 4), "t4_b1r_hs");
        send(pk(1, 2), "t4_a0_hs");
        send(pk(3, 4), "t4_a1_hs");
        wait_done(50, k);
        chk("t4_done_err", 64'({o_done, o_err}), 64'(2'b10));
        tick();
        chk("t4_reload0", 64'({sa_flag(sb), sa_row(sb)}), 64'({3'b110, pk(3, 4)}));
        chk("t4_reload1", 64'({sa_flag(sb + 1), sa_row(sb + 1)}), 64'({3'b110, pk(1, 2)}));
        chk("t4_c1", 64'(c_ent(cb + 1)), 64'({1'b1, pk(15, 22)}));

        // 5: empty job
        sb = sa_rows_log.size();
        start_job(8'd0, 1'b0);
        chk("t5_done", 64'({o_busy, o_done, o_err, o_row_rdy}), 64'(4'b0100));
        tick();
        chk("t5_pulse_end", 64'({o_busy, o_done, o_row_rdy}), 64'(0));
        tick();
        chk("t5_no_traffic", 64'(sa_rows_log.size() - sb), 64'(0));

        // 6: array never answers -> timeout exactly TIMEOUT cycles into DRAIN
        stub = 1'b1;
        cb = c_rows_log.size();
        start_job(8'd2, 1'b1);
        send(pk(1, 2), "t6_a0_hs");
        send(pk(3, 4), "t6_a1_hs");
        wait_done(200, k);
        chk("t6_timeout_cycles", 64'(k), 64'(64));
        chk("t6_done_err", 64'({o_done, o_err}), 64'(2'b11));
        chk("t6_no_c", 64'(c_rows_log.size() - cb), 64'(0));
        tick();
        start_job(8'd1, 1'b1);
        send(pk(1, 1), "t6_reload_hs");
        chk("t6_b_reload", 64'({o_busy, o_row_rdy}), 64'(2'b11));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stub = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
